xif_mac_coproc: RTL and testbench
=================================

// Module: xif_mac_coproc
// PURPOSE
//  eXtension-interface coprocessor downstream of the cv32e40x core: accepts custom-0 MADD/MSUB offloads.
//  Uses all three source operands (X_NUM_RS=3): rd = rs3 +/- rs1*rs2, low 32 bits.
//  Handshakes are issue -> commit -> result. One instruction in flight. Multiplier is a 32-cycle shift-add.
// PARAMETERS
//  XLEN        32          operand/result width (only 32 supported)
//  X_ID_WIDTH  4           width of the offload instruction id
//  X_NUM_RS    3           source register ports; must be 3
//  OPCODE      7'b0001011  custom-0 major opcode decoded
// PORTS
//  clk_i              in   1           clock
//  rst_ni             in   1           synchronous active-low reset
//  issue_valid_i      in   1           issue request valid
//  issue_ready_o      out  1           coprocessor can take an issue
//  issue_instr_i      in   32          offloaded instruction word
//  issue_id_i         in   X_ID_WIDTH  instruction id
//  issue_rs_i         in   3*XLEN      {rs3,rs2,rs1} operand values
//  issue_rs_valid_i   in   3           per-operand valid
//  issue_accept_o     out  1           instruction accepted (qualified by issue handshake)
//  issue_writeback_o  out  1           accepted instruction writes rd
//  commit_valid_i     in   1           commit message valid
//  commit_id_i        in   X_ID_WIDTH  id being committed or killed
//  commit_kill_i      in   1           1 = kill, 0 = commit
//  result_valid_o     out  1           result valid
//  result_ready_i     in   1           core takes the result
//  result_id_o        out  X_ID_WIDTH  id of the result
//  result_rd_o        out  5           destination register (instr[11:7])
//  result_data_o      out  XLEN        rd value
//  result_we_o        out  1           write enable (1 for every emitted result)
// BEHAVIOUR
//  Decode (combinational):
//  - opcode==OPCODE, funct3 000 = MADD (rs3+rs1*rs2), funct3 001 = MSUB (rs3-rs1*rs2).
//  - Any other instruction: accept=0, writeback=0.
//  Issue handshake: issue_valid_i && issue_ready_o.
//  - issue_ready_o=1 only in IDLE and only when issue_rs_valid_i==3'b111.
//  - A non-accepted handshake leaves the block in IDLE.
//  FSM states: IDLE, EXEC, RESULT.
//  - IDLE -> EXEC on an accepted handshake. Capture id, rd, op and rs1/rs2/rs3; clear cnt and committed.
//  - EXEC: one shift-add step per cycle, cnt 0..31. cnt==31 -> RESULT.
//  - In RESULT, result_data_o is registered: rs3 +/- product[31:0], modulo 2^32 (wrap, no flags).
//  - RESULT: result_valid_o = committed. Hold id, rd and data stable until result_ready_i.
//  - valid && ready -> IDLE. issue_ready_o may be 1 in the next cycle.
//  Latency: committed before completion -> result_valid_o high 33 cycles after the issue handshake edge.
//  Commit matching: commit_valid_i && commit_id_i==captured id, in EXEC or RESULT.
//  - kill=0 sets committed. Commit in the RESULT cycle raises result_valid_o in the next cycle.
//  - kill=1 aborts to IDLE next cycle; no result is emitted.
//  - Non-matching ids, and any commit in IDLE, are ignored.
//  - Commit on the same edge as cnt==31 is kept (committed set on entry to RESULT).
//  Reset: synchronous. rst_ni=0 at the clock edge forces IDLE and clears cnt, committed and operands, even mid-EXEC.
//  Reset values: issue_ready_o=0 while in reset, then 1 once in IDLE if rs_valid.
//  Reset values: result_valid_o=0, result_data_o=0, result_id_o=0, result_rd_o=0, result_we_o=0.
//  issue_accept_o and issue_writeback_o are combinational from decode.
// STRUCTURE
//  Package xif_mac_pkg:
//  - OPCODE_CUSTOM0, funct3 enum {F3_MADD=3'b000, F3_MSUB=3'b001}
//  - state_e {IDLE,EXEC,RESULT}, op_e {OP_MADD,OP_MSUB}
//  Sub-module xif_mac_mul_seq:
//  - start/a/b in, busy/done/product[63:0] out, 32-cycle radix-2 shift-add.
//  - Synchronous active-low clear on rst_ni or kill.
//  Top: decode, FSM, commit tracking, result register.
// TESTING
//  1 MADD rs1=3 rs2=5 rs3=7, commit 2 cycles after issue
//    -> accept=1 writeback=1; result_data=22 with rd=instr[11:7] 33 cycles after issue.
//  2 MSUB rs1=6 rs2=7 rs3=100, commit on cycle 40 (late)
//    -> result_valid rises on cycle 41 with data=58.
//  3 MADD rs1=rs2=32'hFFFFFFFF rs3=1 -> data=32'h00000002 (wrap).
//  4 MADD accepted, kill with matching id at cnt==10
//    -> result_valid never rises; issue_ready=1 two cycles later.
//    -> A following MADD 2*2+0 returns 4.
//  5 Committed result held with result_ready_i=0 for 5 cycles
//    -> id, rd and data stable; valid drops the cycle after ready=1.
//  6 funct3=3'b111, or opcode 0110011
//    -> accept=0 writeback=0, stays IDLE, ignores commit; rst_ni=0 mid-EXEC -> IDLE, no result.

Source files
------------

// File: rtl/xif_mac_pkg.sv
// Shared types and constants for the X-interface multiply-accumulate coprocessor.
package xif_mac_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {F3_MADD = 3'b000, F3_MSUB = 3'b001} funct3_e;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESULT = 2'd2} state_e;
  typedef enum logic {OP_MADD = 1'b0, OP_MSUB = 1'b1} op_e;

  // Final accumulate step; wraps modulo 2^32.
  function automatic logic [31:0] mac_combine(op_e op, logic [31:0] acc, logic [31:0] prod);
    return (op == OP_MSUB) ? (acc - prod) : (acc + prod);
  endfunction

endpackage

// File: rtl/xif_mac_mul_seq.sv
// Radix-2 shift-add multiplier: one partial product per cycle, 32 cycles per operation.
module xif_mac_mul_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  // Clear wins over start; a killed instruction leaves no partial state behind.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= 64'd0;
      mcand_q  <= {32'd0, a_i};
      mplier_q <= b_i;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/xif_mac_coproc.sv
// X-interface coprocessor executing custom-0 MADD/MSUB (rd = rs3 +/- rs1*rs2),
// one instruction in flight through issue, commit and result handshakes.
module xif_mac_coproc
  import xif_mac_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter int         X_ID_WIDTH = 4,
  parameter int         X_NUM_RS   = 3,
  parameter logic [6:0] OPCODE     = OPCODE_CUSTOM0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]    issue_id_i,
  input  logic [X_NUM_RS*XLEN-1:0] issue_rs_i,
  input  logic [X_NUM_RS-1:0]      issue_rs_valid_i,
  output logic                     issue_accept_o,
  output logic                     issue_writeback_o,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [4:0]               result_rd_o,
  output logic [XLEN-1:0]          result_data_o,
  output logic                     result_we_o
);

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  committed_q, committed_d;
  op_e                   op_q;
  logic [XLEN-1:0]       rs3_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [4:0]            rd_q;
  logic                  valid_q, valid_d;
  logic                  we_q;
  logic [XLEN-1:0]       data_q, data_d;

  logic        opcode_ok_s, is_madd_s, is_msub_s, accept_s;
  logic        issue_fire_s, commit_hit_s, kill_hit_s, commit_ok_s, res_fire_s;
  logic        mul_busy_s, mul_done_s;
  logic [63:0] product_s;
  logic        unused_s;

  assign opcode_ok_s = (issue_instr_i[6:0] == OPCODE);
  assign is_madd_s   = opcode_ok_s && (issue_instr_i[14:12] == F3_MADD);
  assign is_msub_s   = opcode_ok_s && (issue_instr_i[14:12] == F3_MSUB);
  assign accept_s    = is_madd_s || is_msub_s;

  assign issue_accept_o    = accept_s;
  assign issue_writeback_o = accept_s;
  assign issue_ready_o     = rst_ni && (state_q == IDLE) && (&issue_rs_valid_i);

  assign issue_fire_s = issue_valid_i && issue_ready_o && accept_s;
  assign commit_hit_s = commit_valid_i && (commit_id_i == id_q) && (state_q != IDLE);
  assign kill_hit_s   = commit_hit_s && commit_kill_i;
  assign commit_ok_s  = commit_hit_s && !commit_kill_i;
  assign res_fire_s   = valid_q && result_ready_i;

  xif_mac_mul_seq u_mul (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (kill_hit_s),
    .start_i   (issue_fire_s),
    .a_i       (issue_rs_i[XLEN-1:0]),
    .b_i       (issue_rs_i[2*XLEN-1:XLEN]),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (product_s)
  );

  assign unused_s = ^{issue_instr_i[31:15], product_s[63:32], mul_busy_s, mul_done_s};

  // Next-state, commit tracking and result staging.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (issue_fire_s) begin
          state_d     = EXEC;
          cnt_d       = 5'd0;
          committed_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (kill_hit_s) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (commit_ok_s) begin
            committed_d = 1'b1;
          end else begin
            committed_d = committed_q;
          end
          if (cnt_q == 5'd31) begin
            state_d = RESULT;
          end else begin
            state_d = EXEC;
          end
        end
      end
      RESULT: begin
        if (kill_hit_s) begin
          state_d = IDLE;
        end else if (res_fire_s) begin
          state_d = IDLE;
        end else begin
          // Data freezes once valid is up so the core sees a stable payload.
          if (!valid_q) begin
            data_d = mac_combine(op_q, rs3_q, product_s[XLEN-1:0]);
          end else begin
            data_d = data_q;
          end
          committed_d = committed_q || commit_ok_s;
          valid_d     = committed_q || commit_ok_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured operands and registered result outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      committed_q <= 1'b0;
      op_q        <= OP_MADD;
      rs3_q       <= {XLEN{1'b0}};
      id_q        <= {X_ID_WIDTH{1'b0}};
      rd_q        <= 5'd0;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      data_q      <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      valid_q     <= valid_d;
      we_q        <= valid_d;
      data_q      <= data_d;
      if (issue_fire_s) begin
        op_q  <= is_msub_s ? OP_MSUB : OP_MADD;
        rs3_q <= issue_rs_i[3*XLEN-1:2*XLEN];
        id_q  <= issue_id_i;
        rd_q  <= issue_instr_i[11:7];
      end
    end
  end

  assign result_valid_o = valid_q;
  assign result_we_o    = we_q;
  assign result_id_o    = id_q;
  assign result_rd_o    = rd_q;
  assign result_data_o  = data_q;

endmodule

// File: tb/tb_xif_mac_coproc.sv
// Self-checking bench: directed cases plus randomized offloads against a transaction-level model.
module tb_xif_mac_coproc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ivalid;
  logic        iready;
  logic [31:0] instr;
  logic [3:0]  iid;
  logic [95:0] rs;
  logic [2:0]  rsv;
  logic        accept, wback;
  logic        cvalid;
  logic [3:0]  cid;
  logic        ckill;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [4:0]  rrd;
  logic [31:0] rdata;
  logic        rwe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Transaction-level model state
  bit        m_busy = 1'b0;
  bit        m_out_valid = 1'b0;
  int        m_issue = 0;
  int        m_commit = -1;
  bit [31:0] m_data;
  bit [3:0]  m_id;
  bit [4:0]  m_rd;

  always #5 clk = ~clk;

  xif_mac_coproc dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .issue_valid_i     (ivalid),
    .issue_ready_o     (iready),
    .issue_instr_i     (instr),
    .issue_id_i        (iid),
    .issue_rs_i        (rs),
    .issue_rs_valid_i  (rsv),
    .issue_accept_o    (accept),
    .issue_writeback_o (wback),
    .commit_valid_i    (cvalid),
    .commit_id_i       (cid),
    .commit_kill_i     (ckill),
    .result_valid_o    (rvalid),
    .result_ready_i    (rready),
    .result_id_o       (rid),
    .result_rd_o       (rrd),
    .result_data_o     (rdata),
    .result_we_o       (rwe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_accept(input logic [31:0] w);
    return (w[6:0] == 7'b0001011) && (w[14:12] == 3'b000 || w[14:12] == 3'b001);
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    int rise;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_out_valid = 1'b0;
    end else if (m_out_valid && rready) begin
      m_busy = 1'b0;
      m_out_valid = 1'b0;
    end else if (m_busy) begin
      if (cvalid && cid == m_id) begin
        if (ckill) begin
          m_busy = 1'b0;
          m_out_valid = 1'b0;
        end else if (m_commit < 0) begin
          m_commit = cyc;
        end
      end
      rise = (m_issue + 33 > m_commit) ? m_issue + 33 : m_commit;
      if (m_busy && m_commit >= 0 && cyc >= rise) m_out_valid = 1'b1;
    end else if (ivalid && rsv == 3'b111 && model_accept(instr)) begin
      m_busy   = 1'b1;
      m_issue  = cyc;
      m_commit = -1;
      m_id     = iid;
      m_rd     = instr[11:7];
      if (instr[14:12] == 3'b001) m_data = rs[95:64] - rs[31:0] * rs[63:32];
      else                        m_data = rs[95:64] + rs[31:0] * rs[63:32];
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      model_edge();
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("issue_ready", iready, rst_n && !m_busy && rsv == 3'b111);
      check("issue_accept", accept, model_accept(instr));
      check("issue_writeback", wback, model_accept(instr));
      check("result_valid", rvalid, m_out_valid);
      if (m_out_valid) begin
        check("result_data", rdata, m_data);
        check("result_id", rid, m_id);
        check("result_rd", rrd, m_rd);
        check("result_we", rwe, 1'b1);
      end
    end
  end

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    logic [31:0] w;
    w = 32'h0;
    w[6:0] = opc;
    w[11:7] = rd;
    w[14:12] = f3;
    return w;
  endfunction

  task automatic do_issue(input logic [31:0] w, input logic [3:0] id,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    ivalid = 1'b1;
    instr  = w;
    iid    = id;
    rs     = {c, b, a};
    rsv    = 3'b111;
    step(1);
    ivalid = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    cvalid = 1'b1;
    cid    = id;
    ckill  = kill;
    step(1);
    cvalid = 1'b0;
    ckill  = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int k);
    k = 0;
    while (rvalid !== 1'b1 && k < max) begin
      step(1);
      k++;
    end
  endtask

  task automatic take_result();
    rready = 1'b1;
    step(1);
    rready = 1'b0;
  endtask

  initial begin
    int ic, k;
    bit saw;
    logic [31:0] h_data;
    logic [3:0]  h_id;
    logic [4:0]  h_rd;

    rst_n = 1'b0; ivalid = 1'b0; instr = 32'h0; iid = 4'h0; rs = 96'h0; rsv = 3'b111;
    cvalid = 1'b0; cid = 4'h0; ckill = 1'b0; rready = 1'b0;
    step(2);
    chk_en = 1'b1;
    check("reset_ready", iready, 1'b0);
    check("reset_valid", rvalid, 1'b0);
    check("reset_data", rdata, 32'h0);
    check("reset_id", rid, 4'h0);
    check("reset_rd", rrd, 5'h0);
    check("reset_we", rwe, 1'b0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", iready, 1'b1);

    // 1: MADD 3*5+7, early commit, 33-cycle latency
    instr = mk_instr(7'b0001011, 3'b000, 5'd9);
    #1;
    check("t1_accept", accept, 1'b1);
    check("t1_writeback", wback, 1'b1);
    do_issue(mk_instr(7'b0001011, 3'b000, 5'd9), 4'd3, 32'd3, 32'd5, 32'd7);
    ic = cyc;
    step(2);
    do_commit(4'd3, 1'b0);
    wait_valid(60, k);
    check("t1_latency", cyc - ic, 33);
    check("t1_data", rdata, 32'd22);
    check("t1_rd", rrd, 5'd9);
    take_result();

    // 2: MSUB 100-6*7, commit late
    do_issue(mk_instr(7'b0001011, 3'b001, 5'd20), 4'd4, 32'd6, 32'd7, 32'd100);
    step(40);
    check("t2_not_yet", rvalid, 1'b0);
    do_commit(4'd4, 1'b0);
    check("t2_valid", rvalid, 1'b1);
    check("t2_data", rdata, 32'd58);
    take_result();

    // 3: wrap-around
    do_issue(mk_instr(7'b0001011, 3'b000, 5'd1), 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
    do_commit(4'd2, 1'b0);
    wait_valid(60, k);
    check("t3_data", rdata, 32'h00000002);
    take_result();

    // 4: kill mid-execution, then 2*2+0
    do_issue(mk_instr(7'b0001011, 3'b000, 5'd5), 4'd5, 32'd9, 32'd9, 32'd9);
    step(10);
    do_commit(4'd5, 1'b1);
    check("t4_ready_after_kill", iready, 1'b1);
    saw = 1'b0;
    repeat (40) begin
      step(1);
      if (rvalid === 1'b1) saw = 1'b1;
    end
    check("t4_no_result", saw, 1'b0);
    do_issue(mk_instr(7'b0001011, 3'b000, 5'd6), 4'd6, 32'd2, 32'd2, 32'd0);
    do_commit(4'd6, 1'b0);
    wait_valid(60, k);
    check("t4_data", rdata, 32'd4);
    take_result();

    // 5: backpressure holds the result
    do_issue(mk_instr(7'b0001011, 3'b000, 5'd17), 4'd7, 32'd10, 32'd11, 32'd3);
    do_commit(4'd7, 1'b0);
    wait_valid(60, k);
    h_data = rdata; h_id = rid; h_rd = rrd;
    check("t5_data", h_data, 32'd113);
    repeat (5) begin
      step(1);
      check("t5_hold_valid", rvalid, 1'b1);
      check("t5_hold_data", rdata, h_data);
      check("t5_hold_id", rid, h_id);
      check("t5_hold_rd", rrd, h_rd);
    end
    take_result();
    check("t5_valid_drop", rvalid, 1'b0);

    // 6: non-accepted instructions, stray commits, reset mid-execution
    instr = mk_instr(7'b0001011, 3'b111, 5'd2);
    #1;
    check("t6_accept_f3", accept, 1'b0);
    check("t6_wb_f3", wback, 1'b0);
    do_issue(mk_instr(7'b0001011, 3'b111, 5'd2), 4'd8, 32'd1, 32'd1, 32'd1);
    do_commit(4'd8, 1'b0);
    instr = mk_instr(7'b0110011, 3'b000, 5'd2);
    #1;
    check("t6_accept_op", accept, 1'b0);
    do_issue(mk_instr(7'b0110011, 3'b000, 5'd2), 4'd8, 32'd1, 32'd1, 32'd1);
    do_commit(4'd8, 1'b0);
    step(40);
    check("t6_idle_ready", iready, 1'b1);
    do_issue(mk_instr(7'b0001011, 3'b000, 5'd12), 4'd9, 32'd4, 32'd4, 32'd4);
    do_commit(4'd9, 1'b0);
    step(10);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("t6_rst_data", rdata, 32'h0);
    check("t6_rst_id", rid, 4'h0);
    saw = 1'b0;
    repeat (40) begin
      step(1);
      if (rvalid === 1'b1) saw = 1'b1;
    end
    check("t6_no_result", saw, 1'b0);

    // Randomized offloads
    for (int t = 0; t < 40; t++) begin
      logic [31:0] w;
      int d, budget;
      bit kl;
      w = $urandom;
      w[6:0] = ($urandom % 8 == 0) ? 7'b0110011 : 7'b0001011;
      w[14:12] = ($urandom % 6 == 0) ? 3'b111 : {2'b00, 1'($urandom % 2)};
      ivalid = 1'b1;
      instr  = w;
      iid    = 4'($urandom);
      rs     = {$urandom, $urandom, $urandom};
      repeat ($urandom % 3) begin
        rsv = 3'($urandom % 7);
        step(1);
      end
      rsv = 3'b111;
      step(1);
      ivalid = 1'b0;
      if (m_busy) begin
        d  = $urandom_range(1, 45);
        kl = ($urandom % 5 == 0);
        budget = 0;
        while (m_busy && budget < 200) begin
          rsv    = 3'($urandom);
          rready = 1'($urandom % 2);
          if (budget + 1 == d) begin
            cvalid = 1'b1; cid = m_id; ckill = kl;
          end else if ($urandom % 4 == 0) begin
            cvalid = 1'b1; cid = m_id + 4'd1 + 4'($urandom % 15); ckill = 1'($urandom % 2);
          end else begin
            cvalid = 1'b0; ckill = 1'b0;
          end
          step(1);
          budget++;
        end
        cvalid = 1'b0; ckill = 1'b0; rready = 1'b0; rsv = 3'b111;
        if (m_busy) begin
          total++;
          bad++;
          $display("FAIL rand_timeout: transaction %0d still pending after %0d cycles", t, budget);
          rst_n = 1'b0;
          step(1);
          rst_n = 1'b1;
        end
      end
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
